ctmm_mload: RTL
===============

CTMM_MLOAD -- requirements
Module: ctmm_mload

Interface
REQ-001 The block SHALL import ctmm_pkg and use its capability_reg_t, fault_type_t, PERM_L, PERM_M and PERM_B definitions; it has no parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sub_start  input  1  request to start a load; accepted only in IDLE.
REQ-006 sub_src_cap  input  capability_reg_t  source C-List capability, already read by the caller.
REQ-007 sub_index  input  8  C-List slot index.
REQ-008 sub_busy  output  1  high whenever state is not IDLE.
REQ-009 sub_done  output  1  one-cycle pulse on successful completion.
REQ-010 sub_fault  output  1  one-cycle pulse on fault.
REQ-011 sub_fault_type  output  fault_type_t  cause of the last fault, or FAULT_NONE.
REQ-012 sub_gt  output  64  loaded Golden Token.
REQ-013 mem_rd_addr  output  64  read address.
REQ-014 mem_rd_en  output  1  read request, level-held.
REQ-015 mem_rd_data  input  64  read data, valid when mem_rd_done is high.
REQ-016 mem_rd_done  input  1  read-complete acknowledge.

Function
REQ-017 States SHALL be: IDLE, CHECK_L, CHECK_BOUNDS, READ_GT, CHECK_MB, COMPLETE and FAULT.
REQ-018 In IDLE with sub_start=1, the block SHALL latch sub_src_cap and sub_index, set sub_fault_type to FAULT_NONE, and go to CHECK_L.
REQ-019 sub_start SHALL be ignored in every state other than IDLE, and latched inputs SHALL not change until the next accepted start.
REQ-020 CHECK_L: if latched word0_gt[57:48] bit PERM_L is 0, the block SHALL go to FAULT with FAULT_PERM; otherwise it SHALL go to CHECK_BOUNDS.
REQ-021 CHECK_BOUNDS: if {56'b0,index} >= word2_limit (64-bit unsigned compare), the block SHALL go to FAULT with FAULT_BOUNDS; otherwise it SHALL go to READ_GT.
REQ-022 Limit=0 SHALL always produce FAULT_BOUNDS.
REQ-023 Index=255 with limit=256 SHALL pass the bounds check.
REQ-024 mem_rd_addr SHALL equal word1_location + ({56'b0,index} << 3), computed modulo 2^64 (wrap allowed, no fault).
REQ-025 mem_rd_addr SHALL be driven combinationally from the latched values at all times.
REQ-026 mem_rd_en SHALL be 1 exactly while in READ_GT.
REQ-027 READ_GT SHALL persist until mem_rd_done=1, with no timeout.
REQ-028 On the READ_GT cycle with mem_rd_done=1, the block SHALL capture mem_rd_data into an internal GT register and go to CHECK_MB.
REQ-029 mem_rd_done SHALL be ignored in all other states.
REQ-030 CHECK_MB: if captured bits[57:48] have PERM_M=0 and PERM_B=0, the block SHALL go to FAULT with FAULT_PERM; otherwise it SHALL go to COMPLETE.
REQ-031 M=1 SHALL bypass the B requirement.
REQ-032 COMPLETE SHALL drive sub_done=1 for one cycle and then return to IDLE.
REQ-033 FAULT SHALL drive sub_fault=1 for one cycle and then return to IDLE.
REQ-034 sub_done and sub_fault SHALL never be high together.
REQ-035 sub_gt SHALL be updated only on successful completion: the captured value is presented from the COMPLETE cycle onward and held until the next COMPLETE.
REQ-036 A faulting load SHALL not change sub_gt.
REQ-037 sub_fault_type SHALL hold its value through IDLE until the next accepted start.
REQ-038 Latency with mem_rd_done returned in the first READ_GT cycle SHALL be: start accepted at cycle T, mem_rd_en at T+3, sub_done at T+5.
REQ-039 Fault latency SHALL be: FAULT at T+2 for an L failure, T+3 for a bounds failure, and R+2 for an M/B failure, where R is the done cycle.
REQ-040 An illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-041 rst_n=0 SHALL immediately force state=IDLE, sub_busy=0, sub_done=0, sub_fault=0, mem_rd_en=0, sub_fault_type=FAULT_NONE, sub_gt=0 and all latched registers to 0, including mid-read.
REQ-042 A mem_rd_done arriving after reset SHALL be ignored.

Verification
REQ-043 L=1, location=0x1000, limit=4, index=3, memory returns GT with B=1 one cycle after request -> mem_rd_addr=0x1018, mem_rd_en at T+3, sub_done at T+5, sub_gt equals the returned word, fault_type=FAULT_NONE.
REQ-044 L=0 -> sub_fault at T+2, FAULT_PERM, mem_rd_en never asserted, sub_gt unchanged.
REQ-045 L=1, limit=4, index=4 -> sub_fault at T+3, FAULT_BOUNDS; repeat with limit=0, index=0 -> FAULT_BOUNDS.
REQ-046 Returned GT has M=0 and B=0 -> sub_fault, FAULT_PERM, sub_gt keeps its previous value; returned GT has M=1 and B=0 -> sub_done.
REQ-047 mem_rd_done delayed 7 cycles, with sub_start pulsed during the wait -> mem_rd_en held 8 cycles, extra start ignored, single sub_done.
REQ-048 rst_n low during READ_GT, then mem_rd_done pulsed after release -> block remains in IDLE with all outputs at reset values; location=0xFFFF_FFFF_FFFF_FFF8, index=1 -> mem_rd_addr=0x0 (wrap).

Source files
------------

// File: rtl/ctmm_mload_if.sv
// Memory read port of the C-List load unit.
// Handshake: the master raises mem_rd_en with a stable mem_rd_addr and holds both
// until the slave returns mem_rd_done for one cycle, with mem_rd_data valid in that cycle.
interface ctmm_mload_if;
  logic [63:0] mem_rd_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rd_data;
  logic        mem_rd_done;

  modport master (
    output mem_rd_addr,
    output mem_rd_en,
    input  mem_rd_data,
    input  mem_rd_done
  );

  modport slave (
    input  mem_rd_addr,
    input  mem_rd_en,
    output mem_rd_data,
    output mem_rd_done
  );
endinterface

// File: rtl/ctmm_mload.sv
// C-List capability load: checks L permission and bounds on the source capability,
// reads the Golden Token from memory, then checks its M/B permissions.
package ctmm_pkg;
  // Bit positions inside the 10-bit permission field at word0_gt[57:48].
  localparam int unsigned PERM_L = 3;
  localparam int unsigned PERM_M = 6;
  localparam int unsigned PERM_B = 7;

  typedef struct packed {
    logic [63:0] word2_limit;
    logic [63:0] word1_location;
    logic [63:0] word0_gt;
  } capability_reg_t;

  typedef enum logic [1:0] {
    FAULT_NONE   = 2'd0,
    FAULT_PERM   = 2'd1,
    FAULT_BOUNDS = 2'd2
  } fault_type_t;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CHECK_L      = 3'd1,
    ST_CHECK_BOUNDS = 3'd2,
    ST_READ_GT      = 3'd3,
    ST_CHECK_MB     = 3'd4,
    ST_COMPLETE     = 3'd5,
    ST_FAULT        = 3'd6
  } mload_state_e;

  typedef struct packed {
    mload_state_e    state;
    capability_reg_t cap;
    logic [7:0]      index;
    logic [63:0]     gt_cap;
  } mload_dbg_t;
endpackage

module ctmm_mload
  import ctmm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sub_start,
  input  capability_reg_t    sub_src_cap,
  input  logic [7:0]         sub_index,
  output logic               sub_busy,
  output logic               sub_done,
  output logic               sub_fault,
  output fault_type_t        sub_fault_type,
  output logic [63:0]        sub_gt,
  ctmm_mload_if.master       mem,
  output mload_dbg_t         dbg_o
);

  mload_state_e    state_q, state_d;
  capability_reg_t cap_q, cap_d;
  logic [7:0]      index_q, index_d;
  logic [63:0]     gt_cap_q, gt_cap_d;
  logic [63:0]     gt_q, gt_d;
  fault_type_t     fault_type_q, fault_type_d;

  logic [9:0]      src_perm;
  logic [9:0]      gt_perm;
  logic            bounds_fail;

  assign src_perm    = cap_q.word0_gt[57:48];
  assign gt_perm     = gt_cap_q[57:48];
  assign bounds_fail = ({56'b0, index_q} >= cap_q.word2_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cap_q        <= '0;
      index_q      <= '0;
      gt_cap_q     <= '0;
      gt_q         <= '0;
      fault_type_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      index_q      <= index_d;
      gt_cap_q     <= gt_cap_d;
      gt_q         <= gt_d;
      fault_type_q <= fault_type_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    index_d      = index_q;
    gt_cap_d     = gt_cap_q;
    gt_d         = gt_q;
    fault_type_d = fault_type_q;
    case (state_q)
      ST_IDLE: begin
        if (sub_start) begin
          cap_d        = sub_src_cap;
          index_d      = sub_index;
          fault_type_d = FAULT_NONE;
          state_d      = ST_CHECK_L;
        end
      end
      ST_CHECK_L: begin
        if (!src_perm[PERM_L]) begin
          fault_type_d = FAULT_PERM;
          state_d      = ST_FAULT;
        end else begin
          state_d = ST_CHECK_BOUNDS;
        end
      end
      ST_CHECK_BOUNDS: begin
        if (bounds_fail) begin
          fault_type_d = FAULT_BOUNDS;
          state_d      = ST_FAULT;
        end else begin
          state_d = ST_READ_GT;
        end
      end
      ST_READ_GT: begin
        if (mem.mem_rd_done) begin
          gt_cap_d = mem.mem_rd_data;
          state_d  = ST_CHECK_MB;
        end
      end
      ST_CHECK_MB: begin
        // M grants the load on its own; B is only required when M is clear.
        if (!gt_perm[PERM_M] && !gt_perm[PERM_B]) begin
          fault_type_d = FAULT_PERM;
          state_d      = ST_FAULT;
        end else begin
          gt_d    = gt_cap_q;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: state_d = ST_IDLE;
      ST_FAULT:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign sub_busy       = (state_q != ST_IDLE);
  assign sub_done       = (state_q == ST_COMPLETE);
  assign sub_fault      = (state_q == ST_FAULT);
  assign sub_fault_type = fault_type_q;
  assign sub_gt         = gt_q;

  // Address wraps modulo 2^64 by construction of the 64-bit add.
  assign mem.mem_rd_addr = cap_q.word1_location + {53'b0, index_q, 3'b000};
  assign mem.mem_rd_en   = (state_q == ST_READ_GT);

  assign dbg_o.state  = state_q;
  assign dbg_o.cap    = cap_q;
  assign dbg_o.index  = index_q;
  assign dbg_o.gt_cap = gt_cap_q;

endmodule
